// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 set-2 scan-code parser with show-ahead event queue
// Turns E0/F0-prefixed byte sequences into {code, ext, break} events with sticky error flags.

module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_tdata,
  input  logic             wr_tvalid,
  output logic [WIDTH-1:0] rd_tdata,
  output logic             rd_tvalid,
  input  logic             rd_tready,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] last_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign pop      = !empty && rd_tready;
  // A full queue still accepts a write when the head leaves on the same edge.
  assign push     = wr_tvalid && (!full || pop);
  assign overflow = wr_tvalid && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // The last popped entry stays visible while empty so outputs never show stale storage.
  assign rd_tdata  = empty ? last_q : mem[rd_ptr];
  assign rd_tvalid = !empty;
  assign count     = cnt;

endmodule

module ps2_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    code,
  input  logic                          code_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    err_status,
  input  logic                          err_clr
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] tmo_cnt;
  logic          timeout_hit;
  logic          is_e0;
  logic          is_f0;
  logic          is_bad;
  logic          is_ignored;
  logic          emit;
  logic          emit_ext;
  logic          emit_brk;
  logic          set_timeout;
  logic          set_overrun;
  logic          fifo_ovf;
  logic [9:0]    head;
  logic [2:0]    err_q;

  assign is_e0      = (code == 8'hE0);
  assign is_f0      = (code == 8'hF0);
  assign is_bad     = (code == 8'h00) || (code == 8'hFF);
  // Keyboard status replies are meaningless as keys when no prefix is pending.
  assign is_ignored = (code == 8'hAA) || (code == 8'hFA) || (code == 8'hEE) ||
                      (code == 8'hFC) || (code == 8'hFD);

  assign timeout_hit = (state_q != S_IDLE) && !code_valid &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (code_valid) begin
      if (is_bad) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (is_e0)      state_d = S_EXT;
            else if (is_f0) state_d = S_BRK;
            else            state_d = S_IDLE;
          end
          S_EXT: begin
            if (is_f0)      state_d = S_EXT_BRK;
            else if (is_e0) state_d = S_EXT;
            else            state_d = S_IDLE;
          end
          S_BRK: begin
            if (is_e0)      state_d = S_EXT_BRK;
            else if (is_f0) state_d = S_BRK;
            else            state_d = S_IDLE;
          end
          S_EXT_BRK: begin
            if (is_e0 || is_f0) state_d = S_EXT_BRK;
            else                state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (timeout_hit) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    emit        = 1'b0;
    emit_ext    = 1'b0;
    emit_brk    = 1'b0;
    set_timeout = 1'b0;
    set_overrun = 1'b0;
    if (code_valid) begin
      if (is_bad) begin
        set_overrun = 1'b1;
      end else if (state_q == S_IDLE) begin
        emit = !is_e0 && !is_f0 && !is_ignored;
      end else begin
        emit     = !is_e0 && !is_f0;
        emit_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
        emit_brk = (state_q == S_BRK) || (state_q == S_EXT_BRK);
      end
    end else begin
      set_timeout = timeout_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (code_valid || state_q == S_IDLE || timeout_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_tdata  ({emit_ext, emit_brk, code}),
    .wr_tvalid (emit),
    .rd_tdata  (head),
    .rd_tvalid (ev_valid),
    .rd_tready (ev_ready),
    .count     (fifo_count),
    .overflow  (fifo_ovf)
  );

  // Set beats clear so an error landing on the clear cycle is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= (err_clr ? 3'b000 : err_q) | {set_overrun, set_timeout, fifo_ovf};
    end
  end

  assign ev_code    = head[7:0];
  assign ev_break   = head[8];
  assign ev_ext     = head[9];
  assign err_status = err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - scoreboard bench for ps2_scancode_decoder
// Reference parser tracks pending prefixes as two booleans; expected events live in a queue.

module tb_ps2_scancode_decoder;

  localparam int T     = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] code;
  logic       code_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] fifo_count;
  logic [2:0] err_status;
  logic       err_clr;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  logic       m_ext;
  logic       m_brk;
  int         m_idle;
  logic [2:0] exp_err;

  ps2_scancode_decoder #(
    .TIMEOUT_CYCLES (T),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code       (code),
    .code_valid (code_valid),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_break   (ev_break),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .fifo_count (fifo_count),
    .err_status (err_status),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted head event must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_event: got %0h/%0b/%0b expected none", ev_code, ev_ext, ev_break);
      end else begin
        chk("event", {22'd0, ev_ext, ev_break, ev_code}, {22'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_status(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFC) || (b == 8'hFD);
  endfunction

  task automatic model_push(input logic [7:0] b, inout logic [2:0] set);
    if (exp_q.size() >= DEPTH && !ev_ready) set[0] = 1'b1;
    else exp_q.push_back({m_ext, m_brk, b});
  endtask

  // One clock cycle of stimulus with the reference model updated alongside.
  task automatic tick(input logic v, input logic [7:0] b, input logic clr);
    logic [2:0] set;
    set        = 3'b000;
    code_valid = v;
    code       = b;
    err_clr    = clr;
    if (v) begin
      m_idle = 0;
      if (b == 8'h00 || b == 8'hFF) begin
        m_ext = 1'b0; m_brk = 1'b0; set[2] = 1'b1;
      end else if (b == 8'hE0) begin
        m_ext = 1'b1;
      end else if (b == 8'hF0) begin
        m_brk = 1'b1;
      end else if (!m_ext && !m_brk && is_status(b)) begin
        set = set;
      end else begin
        model_push(b, set);
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle == T) begin
        m_ext = 1'b0; m_brk = 1'b0; m_idle = 0; set[1] = 1'b1;
      end
    end
    exp_err = (clr ? 3'b000 : exp_err) | set;
    step();
    code_valid = 1'b0;
    err_clr    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_idle = 0; exp_err = 3'b000;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] fill [5];
    fill[0] = 8'h15; fill[1] = 8'h16; fill[2] = 8'h1E; fill[3] = 8'h26; fill[4] = 8'h25;
    rst_n = 1'b0; code = 8'h00; code_valid = 1'b0; ev_ready = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_err", err_status, 0);
    rst_n = 1'b1;
    step();

    // Make then break with latency checks.
    ev_ready = 1'b1;
    tick(1'b1, 8'h1C, 1'b0);
    chk("latency_make", ev_valid, 1);
    tick(1'b1, 8'hF0, 1'b0);
    chk("prefix_no_event", ev_valid, 0);
    tick(1'b1, 8'h1C, 1'b0);
    chk("latency_break", ev_valid, 1);
    tick(1'b1, 8'hE0, 1'b0);
    tick(1'b1, 8'h75, 1'b0);
    tick(1'b1, 8'hE0, 1'b0);
    tick(1'b1, 8'hF0, 1'b0);
    tick(1'b1, 8'h75, 1'b0);
    idle(2);
    chk("count_drained", fifo_count, 0);

    // Overflow: five makes with the consumer stalled.
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b1, fill[i], 1'b0);
    chk("full_count", fifo_count, 4);
    chk("overflow_err", err_status, 3'b001);
    chk("full_head", ev_code, 8'h15);
    ev_ready = 1'b1;
    idle(5);
    chk("overflow_drained", fifo_count, 0);
    chk("queue_empty_after_ovf", exp_q.size(), 0);

    // Simultaneous push and pop on a full queue.
    tick(1'b0, 8'h00, 1'b1);
    chk("clr_alone", err_status, 0);
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b1, fill[i], 1'b0);
    ev_ready = 1'b1;
    tick(1'b1, 8'h2E, 1'b0);
    chk("full_pushpop_count", fifo_count, 4);
    chk("full_pushpop_noovf", err_status, 0);
    idle(6);
    chk("hold_last", ev_code, 8'h2E);

    // Prefix timeout, then the boundary where a byte coincides with the timeout count.
    tick(1'b1, 8'hE0, 1'b0);
    idle(T);
    chk("timeout_err", err_status, 3'b010);
    chk("timeout_no_event", fifo_count, 0);
    tick(1'b1, 8'h1C, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'hE0, 1'b0);
    idle(T - 1);
    tick(1'b1, 8'h75, 1'b0);
    chk("byte_beats_timeout", err_status, 3'b000);
    idle(2);

    // Overrun byte, clear, and set-versus-clear collision.
    tick(1'b1, 8'hF0, 1'b0);
    tick(1'b1, 8'hFF, 1'b0);
    chk("overrun_no_event", ev_valid, 0);
    tick(1'b1, 8'h1C, 1'b0);
    chk("overrun_err", err_status, 3'b100);
    tick(1'b0, 8'h00, 1'b1);
    chk("clr_overrun", err_status, 0);
    tick(1'b1, 8'hFF, 1'b1);
    chk("set_beats_clr", err_status, 3'b100);
    tick(1'b1, 8'hAA, 1'b0);
    chk("status_dropped", ev_valid, 0);
    idle(2);

    // Reset in the middle of a sequence with events buffered.
    ev_ready = 1'b0;
    tick(1'b1, 8'h1C, 1'b0);
    tick(1'b1, 8'hF0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_valid", ev_valid, 0);
    chk("midrst_flags", {ev_code, ev_ext, ev_break}, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_err", err_status, 0);
    step();
    rst_n = 1'b1;
    step();
    ev_ready = 1'b1;
    tick(1'b1, 8'h1C, 1'b0);
    idle(2);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      ev_ready = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 11))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF) : 8'h12;
        5:       b = 8'hFA;
        default: b = 8'($urandom_range(1, 254));
      endcase
      tick($urandom_range(0, 2) != 0, b, $urandom_range(0, 19) == 0);
      chk("rand_count", fifo_count, exp_q.size());
      chk("rand_err", err_status, exp_err);
    end
    ev_ready = 1'b1;
    idle(8);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_count", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 frame receiver and consumes its 8-bit received bytes, one valid strobe per byte.
- Parses scan-code set 2 prefix sequences (E0 = extended, F0 = break) into single key events: code, extended flag, make/break flag.
- Buffers events in a small show-ahead FIFO with a valid/ready handshake toward the keyboard consumer (display/ASCII stage).
- Provides prefix timeout recovery and sticky error status.

Parameters:
- TIMEOUT_CYCLES, 1000000, cycles allowed between a prefix byte and the following byte before the parser abandons the sequence.
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- code  input  8  received byte from the PS/2 receiver; sampled only when code_valid=1.
- code_valid  input  1  one-cycle strobe: code holds a new byte.
- ev_code  output  8  scan code of the head event.
- ev_ext  output  1  head event was E0-prefixed.
- ev_break  output  1  head event is a key release (F0-prefixed).
- ev_valid  output  1  FIFO non-empty; ev_* are valid.
- ev_ready  input  1  consumer accepts the head event when ev_valid & ev_ready.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored events.
- err_status  output  3  sticky flags: [0] overflow (event dropped), [1] timeout, [2] overrun byte (0x00/0xFF).
- err_clr  input  1  clears all err_status bits.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, timeout counter=0, FIFO empty, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, fifo_count=0, err_status=0. Reset mid-sequence discards any partial prefix and all buffered events.
- FSM states: IDLE, EXT, BRK, EXT_BRK. The FSM advances only on cycles with code_valid=1; the timeout is the only exception.
- IDLE: E0 -> EXT; F0 -> BRK; 0xAA, 0xFA, 0xEE, 0xFC, 0xFD -> dropped, stay IDLE; any other byte -> emit {code, ext=0, brk=0}, stay IDLE.
- EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> emit {code, 1, 0} -> IDLE.
- BRK: F0 -> stay BRK; E0 -> EXT_BRK; other -> emit {code, 0, 1} -> IDLE.
- EXT_BRK: E0 or F0 -> stay EXT_BRK; other -> emit {code, 1, 1} -> IDLE.
- Bytes 0x00 or 0xFF in any state: no emit; FSM -> IDLE; set err_status[2]. These take priority over all rules above.
- Emit decode is combinational from state and code; the FIFO write occurs on the same edge.
- Latency: a code_valid in cycle N into an empty FIFO gives ev_valid=1 in cycle N+1.
- Timeout counter: cleared on every code_valid and while in IDLE; otherwise increments by 1 per cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no code_valid that cycle: FSM -> IDLE, counter -> 0, err_status[1] set, no emit.
  - If code_valid coincides with that count, the byte wins and is processed normally.
- FIFO: entries are 10 bits {ext, brk, code}; show-ahead, so ev_* always reflect the head entry. Pop occurs when ev_valid & ev_ready.
  - Push when full without a simultaneous pop: event dropped, contents unchanged, err_status[0] set.
  - Push when full with a simultaneous pop: both happen; count stays FIFO_DEPTH.
  - Push and pop on a non-empty, non-full FIFO: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_* hold their last value when empty; the consumer must qualify them with ev_valid.
- err_status: each bit is set-only until err_clr. If set and err_clr occur in the same cycle, set wins (bit is 1 next cycle).

Test Plan:
- Bytes 1C, then F0 1C, with ev_ready=1 -> two events {1C,ext0,brk0} then {1C,0,1}; ev_valid asserted the cycle after each final byte.
- Bytes E0 75, then E0 F0 75 -> {75,1,0} then {75,1,1}; fifo_count returns to 0 after pops.
- ev_ready=0, send 5 make codes 15,16,1E,26,25 -> fifo_count=4, err_status=3'b001, head ev_code=15.
  - Then ev_ready=1 -> pops 15,16,1E,26 in order; 25 is lost.
  - Full FIFO with simultaneous push and pop -> fifo_count stays 4, no overflow flag.
- Byte E0, then idle TIMEOUT_CYCLES cycles (bench TIMEOUT_CYCLES=16) -> err_status[1]=1, no event.
  - A following byte 1C -> {1C,0,0}, not extended.
- Bytes F0 FF 1C -> no event for FF, err_status[2]=1, then {1C,0,0}.
  - Pulse err_clr alone -> err_status=0.
  - err_clr coincident with an FF byte -> err_status[2]=1.
- Bytes F0 then assert rst_n=0 mid-sequence; release, send 1C -> {1C,0,0}; all outputs 0 during reset.
